// File: rtl/poly_addsub_stream.sv
// Streaming lane-parallel (A +/- B) mod q engine over three BRAM ports, one word per cycle.
// Optional macro POLY_ADDSUB_OUTREG_EN adds a second output register stage (+1 cycle on writes/done).
module poly_addsub_stream #(
  parameter int KYBER_Q = 3329,
  parameter int LANES   = 8,
  parameter int A_W     = 12,
  parameter int B_W     = 16,
  parameter int OUT_W   = 16,
  parameter int AD_W    = 8,
  parameter int RD_LAT  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mode,
  input  logic [AD_W-1:0]        a_base,
  input  logic [AD_W-1:0]        b_base,
  input  logic [AD_W-1:0]        w_base,
  input  logic [AD_W-1:0]        len,
  output logic                   rd_en,
  output logic [AD_W-1:0]        a_rad,
  output logic [AD_W-1:0]        b_rad,
  input  logic [LANES*A_W-1:0]   a_rdata,
  input  logic [LANES*B_W-1:0]   b_rdata,
  output logic                   wen,
  output logic [AD_W-1:0]        wad,
  output logic [LANES*OUT_W-1:0] wdata,
  output logic                   busy,
  output logic                   done
);
  localparam int OPW = ((A_W > B_W) ? A_W : B_W) + 2;
  localparam logic signed [OPW-1:0] QS = OPW'(KYBER_Q);
  localparam logic [AD_W-1:0] AD_ONE = AD_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state;
  logic                   mode_r;
  logic [AD_W-1:0]        len_r;
  logic [AD_W-1:0]        rcnt;
  logic [AD_W-1:0]        wptr;
  logic [RD_LAT-1:0]      vld_tag;
  logic                   vld_p0;
  logic [LANES*OUT_W-1:0] res_p0;
  logic                   accept;
  logic                   fin;
  logic                   pend;

  function automatic logic signed [OPW-1:0] red_once(input logic signed [OPW-1:0] x);
    return (x >= QS) ? x - QS : x;
  endfunction

  function automatic logic [OUT_W-1:0] mod_addsub(input logic md,
                                                  input logic signed [OPW-1:0] a,
                                                  input logic signed [OPW-1:0] b);
    logic signed [OPW-1:0] r;
    if (md) begin
      r = a + b;
      if (r >= QS) r = r - QS;
    end else begin
      r = a - b;
      if (r < 0) r = r + QS;
    end
    return OUT_W'(unsigned'(r));
  endfunction

  assign accept = (state == IDLE) && start && !done;
  assign vld_p0 = vld_tag[RD_LAT-1];

  // stage p0: read data present, lanes reduced combinationally
  always_comb begin
    res_p0 = '0;
    for (int i = 0; i < LANES; i++) begin
      res_p0[i*OUT_W +: OUT_W] = mod_addsub(mode_r,
                                            red_once(OPW'(a_rdata[i*A_W +: A_W])),
                                            red_once(OPW'(b_rdata[i*B_W +: B_W])));
    end
  end

`ifdef POLY_ADDSUB_OUTREG_EN
  logic                   vld_p1;
  logic [LANES*OUT_W-1:0] res_p1;
  logic [AD_W-1:0]        wad_p1;
  assign fin  = vld_p1;
  assign pend = |vld_tag;
`else
  localparam logic [RD_LAT-1:0] TAG_LAST = RD_LAT'(1) << (RD_LAT - 1);
  assign fin  = vld_p0;
  assign pend = |(vld_tag & ~TAG_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_en   <= 1'b0;
      a_rad   <= '0;
      b_rad   <= '0;
      rcnt    <= '0;
      len_r   <= '0;
      mode_r  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      vld_tag <= '0;
    end else begin
      done       <= 1'b0;
      vld_tag[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) vld_tag[i] <= vld_tag[i-1];
      case (state)
        IDLE: begin
          if (accept) begin
            mode_r <= mode;
            len_r  <= len;
            a_rad  <= a_base;
            b_rad  <= b_base;
            rcnt   <= '0;
            busy   <= 1'b1;
            if (len == '0) begin
              state <= DONE;
            end else begin
              state <= RUN;
              rd_en <= 1'b1;
            end
          end
        end
        RUN: begin
          if (rcnt == len_r - AD_ONE) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            rcnt  <= rcnt + AD_ONE;
            a_rad <= a_rad + AD_ONE;
            b_rad <= b_rad + AD_ONE;
          end
        end
        // leave once the final write is being registered with nothing behind it
        DRAIN: if (fin && !pend) state <= DONE;
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen    <= 1'b0;
      wad    <= '0;
      wdata  <= '0;
      wptr   <= '0;
`ifdef POLY_ADDSUB_OUTREG_EN
      vld_p1 <= 1'b0;
      res_p1 <= '0;
      wad_p1 <= '0;
`endif
    end else begin
      if (accept) wptr <= w_base;
      else if (vld_p0) wptr <= wptr + AD_ONE;
`ifdef POLY_ADDSUB_OUTREG_EN
      // stage p1: extra register for timing, then output register
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        res_p1 <= res_p0;
        wad_p1 <= wptr;
      end
      wen <= vld_p1;
      if (vld_p1) begin
        wdata <= res_p1;
        wad   <= wad_p1;
      end
`else
      wen <= vld_p0;
      if (vld_p0) begin
        wdata <= res_p0;
        wad   <= wptr;
      end
`endif
    end
  end
endmodule

// File: tb/tb_poly_addsub_stream.sv
// Self-checking bench for poly_addsub_stream: vector table, corner sequences and random jobs
// against a plain-arithmetic mod-q reference and an event log of reads/writes/done.
module tb_poly_addsub_stream;
  localparam int Q = 3329, LANES = 8, A_W = 12, B_W = 16, OUT_W = 16, AD_W = 8, RD_LAT = 1;
`ifdef POLY_ADDSUB_OUTREG_EN
  localparam int OR_D = 1;
`else
  localparam int OR_D = 0;
`endif

  logic clk, rst_n, start, mode, rd_en, wen, busy, done;
  logic [AD_W-1:0] a_base, b_base, w_base, len, a_rad, b_rad, wad;
  logic [LANES*A_W-1:0] a_rdata;
  logic [LANES*B_W-1:0] b_rdata;
  logic [LANES*OUT_W-1:0] wdata;

  poly_addsub_stream #(.KYBER_Q(Q), .LANES(LANES), .A_W(A_W), .B_W(B_W), .OUT_W(OUT_W),
                       .AD_W(AD_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .a_base(a_base), .b_base(b_base), .w_base(w_base), .len(len),
    .rd_en(rd_en), .a_rad(a_rad), .b_rad(b_rad), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .wen(wen), .wad(wad), .wdata(wdata), .busy(busy), .done(done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [LANES*A_W-1:0] mem_a [256];
  logic [LANES*B_W-1:0] mem_b [256];
  logic [LANES*A_W-1:0] a_pipe [RD_LAT];
  logic [LANES*B_W-1:0] b_pipe [RD_LAT];

  always @(posedge clk) begin
    a_pipe[0] <= rd_en ? mem_a[a_rad] : '0;
    b_pipe[0] <= rd_en ? mem_b[b_rad] : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      a_pipe[i] <= a_pipe[i-1];
      b_pipe[i] <= b_pipe[i-1];
    end
  end
  assign a_rdata = a_pipe[RD_LAT-1];
  assign b_rdata = b_pipe[RD_LAT-1];

  typedef struct {int c; logic [7:0] ad; logic [127:0] d;} wr_t;
  typedef struct {int c; logic [7:0] a; logic [7:0] b;} rd_t;
  wr_t wr_q[$];
  rd_t rd_q[$];
  int  done_q[$];
  int  busy_cnt = 0;

  always @(negedge clk) begin
    if (wen) wr_q.push_back('{cyc, wad, wdata});
    if (rd_en) rd_q.push_back('{cyc, a_rad, b_rad});
    if (done) done_q.push_back(cyc);
    if (busy) busy_cnt++;
  end

  int nvec = 0, nbad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int ref_lane(input bit md, input int a, input int b);
    int x, y;
    x = a % Q;
    y = b % Q;
    return md ? (x + y) % Q : (x - y + Q) % Q;
  endfunction

  function automatic logic [127:0] exp_word(input bit md, input logic [95:0] aw, input logic [127:0] bw);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      r[i*OUT_W +: OUT_W] = 16'(ref_lane(md, int'(aw[i*A_W +: A_W]), int'(bw[i*B_W +: B_W])));
    return r;
  endfunction

  task automatic fill_rand(input logic [7:0] ab, input logic [7:0] bb, input int n);
    logic [7:0] ia, ib;
    for (int k = 0; k < n; k++) begin
      ia = ab + 8'(k);
      ib = bb + 8'(k);
      for (int i = 0; i < LANES; i++) begin
        mem_a[ia][i*A_W +: A_W] = 12'($urandom_range(0, 4095));
        mem_b[ib][i*B_W +: B_W] = 16'($urandom_range(0, 2*Q - 1));
      end
    end
  endtask

  task automatic run_job(input bit md, input logic [7:0] ab, input logic [7:0] bb,
                         input logic [7:0] wb, input int n, input bit interfere);
    int t0, lat, wr0, rd0, dn0, bz0;
    logic [7:0] ak, bk, wk;
    wr0 = wr_q.size(); rd0 = rd_q.size(); dn0 = done_q.size(); bz0 = busy_cnt;
    @(negedge clk);
    mode = md; a_base = ab; b_base = bb; w_base = wb; len = 8'(n); start = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0; mode = ~md;
    a_base = 8'($urandom); b_base = 8'($urandom); w_base = 8'($urandom); len = 8'($urandom);
    if (interfere) begin
      repeat (2) @(negedge clk);
      start = 1'b1; len = 8'd5; mode = ~md; a_base = 8'd3;
      @(negedge clk);
      start = 1'b0;
    end
    lat = (n == 0) ? 2 : n + RD_LAT + 2 + OR_D;
    for (int i = 0; i < lat + 8 && done_q.size() == dn0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("done_count", done_q.size() - dn0, 1);
    if (done_q.size() > dn0) chk("done_cycle", done_q[dn0] - t0, lat);
    chk("busy_cycles", busy_cnt - bz0, lat - 1);
    chk("read_count", rd_q.size() - rd0, n);
    chk("write_count", wr_q.size() - wr0, n);
    for (int k = 0; k < n; k++) begin
      ak = ab + 8'(k); bk = bb + 8'(k); wk = wb + 8'(k);
      if (rd0 + k < rd_q.size()) begin
        chk("read_cycle", rd_q[rd0+k].c - t0, 1 + k);
        chk("read_a_addr", rd_q[rd0+k].a, ak);
        chk("read_b_addr", rd_q[rd0+k].b, bk);
      end
      if (wr0 + k < wr_q.size()) begin
        chk("write_cycle", wr_q[wr0+k].c - t0, 2 + k + RD_LAT + OR_D);
        chk("write_addr", wr_q[wr0+k].ad, wk);
        chk("write_data", wr_q[wr0+k].d, exp_word(md, mem_a[ak], mem_b[bk]));
      end
    end
  endtask

  typedef struct {bit md; int a; int b; int r;} vec_t;

  initial begin
    vec_t tbl[10];
    int wr0, rd0, dn0, n;
    logic [7:0] ab, bb, wb;
    logic [127:0] w;

    tbl[0] = '{0, 5, 10, 3324};
    tbl[1] = '{0, 3328, 0, 3328};
    tbl[2] = '{0, 7, 3336, 0};
    tbl[3] = '{1, 3000, 1000, 671};
    tbl[4] = '{1, 0, 3328, 3328};
    tbl[5] = '{0, 0, 0, 0};
    tbl[6] = '{1, 3328, 3328, 3327};
    tbl[7] = '{0, 3329, 3328, 1};
    tbl[8] = '{1, 4095, 4095, 1532};
    tbl[9] = '{0, 0, 6657, 1};

    rst_n = 1'b0; start = 1'b0; mode = 1'b0;
    a_base = '0; b_base = '0; w_base = '0; len = '0;
    for (int i = 0; i < 256; i++) fill_rand(8'(i), 8'(i), 1);
    repeat (3) @(negedge clk);
    chk("reset_ctl", {rd_en, wen, busy, done}, 0);
    chk("reset_addr", {a_rad, b_rad, wad}, 0);
    chk("reset_wdata", wdata, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      ab = 8'($urandom); bb = 8'($urandom); wb = 8'($urandom);
      fill_rand(ab, bb, 2);
      mem_a[ab] = {LANES{12'(tbl[i].a)}};
      mem_b[bb] = {LANES{16'(tbl[i].b)}};
      wr0 = wr_q.size();
      run_job(tbl[i].md, ab, bb, wb, 2, 1'b0);
      if (wr_q.size() > wr0) chk("table_lanes", wr_q[wr0].d, {LANES{16'(tbl[i].r)}});
    end

    // subtract across the address wrap with corner lanes
    fill_rand(8'd254, 8'd126, 4);
    mem_a[254][0 +: 12] = 12'd5;    mem_b[126][0 +: 16]  = 16'd10;
    mem_a[254][12 +: 12] = 12'd3328; mem_b[126][16 +: 16] = 16'd0;
    mem_a[254][24 +: 12] = 12'd7;    mem_b[126][32 +: 16] = 16'd3336;
    wr0 = wr_q.size();
    run_job(1'b0, 8'd254, 8'd126, 8'd0, 4, 1'b0);
    if (wr_q.size() > wr0) begin
      w = wr_q[wr0].d;
      chk("wrap_lane0", w[15:0], 3324);
      chk("wrap_lane1", w[31:16], 3328);
      chk("wrap_lane2", w[47:32], 0);
    end

    // add, 32-word burst
    fill_rand(8'd10, 8'd200, 32);
    for (int k = 0; k < 32; k++) begin
      mem_a[8'(10 + k)][0 +: 12] = 12'd3000; mem_b[8'(200 + k)][0 +: 16] = 16'd1000;
      mem_a[8'(10 + k)][12 +: 12] = 12'd0;   mem_b[8'(200 + k)][16 +: 16] = 16'd3328;
    end
    wr0 = wr_q.size();
    run_job(1'b1, 8'd10, 8'd200, 8'd100, 32, 1'b0);
    if (wr_q.size() >= wr0 + 32) begin
      w = wr_q[wr0+31].d;
      chk("burst_lane0", w[15:0], 671);
      chk("burst_lane1", w[31:16], 3328);
    end

    run_job(1'b0, 8'd50, 8'd60, 8'd70, 0, 1'b0);

    fill_rand(8'd40, 8'd41, 12);
    run_job(1'b0, 8'd40, 8'd41, 8'd42, 12, 1'b1);

    for (int j = 0; j < 6; j++) begin
      ab = 8'($urandom); bb = 8'($urandom); wb = 8'($urandom);
      n = $urandom_range(1, 40);
      fill_rand(ab, bb, n);
      run_job(1'($urandom), ab, bb, wb, n, 1'b0);
    end

    // abort a running job with reset
    fill_rand(8'd20, 8'd30, 20);
    @(negedge clk);
    mode = 1'b1; a_base = 8'd20; b_base = 8'd30; w_base = 8'd40; len = 8'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ctl", {rd_en, wen, busy, done}, 0);
    chk("abort_addr", {a_rad, b_rad, wad}, 0);
    chk("abort_wdata", wdata, 0);
    @(negedge clk);
    wr0 = wr_q.size(); rd0 = rd_q.size(); dn0 = done_q.size();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_q.size() - dn0, 0);
    chk("abort_no_write", wr_q.size() - wr0, 0);
    chk("abort_no_read", rd_q.size() - rd0, 0);
    fill_rand(8'd7, 8'd8, 5);
    run_job(1'b1, 8'd7, 8'd8, 8'd9, 5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
